hdma_controller: RTL

- CGB VRAM DMA controller. Implements registers FF51–FF55 and copies data from the CPU address space into VRAM in 16-byte blocks.
- Two modes: general-purpose DMA (GDMA, all blocks back-to-back, CPU stalled) and HBlank DMA (HDMA, one block per HBlank).
- Sits beside the video block. It arbitrates VRAM write access against the PPU using the PPU `mode` output, and stalls the CPU via `dma_busy`.

---
 rtl/video_pkg.sv | 25 ++
 rtl/hdma_byte_engine.sv | 63 ++++++
 rtl/hdma_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video-side blocks: HDMA state encoding,
// PPU STAT mode values and the FF5x register offsets.
package video_pkg;

  localparam int BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    GDMA_XFER,
    HDMA_WAIT,
    HDMA_XFER
  } hdma_state_t;

  localparam logic [1:0] MODE_HBLANK = 2'b00;
  localparam logic [1:0] MODE_VBLANK = 2'b01;
  localparam logic [1:0] MODE_OAM    = 2'b10;
  localparam logic [1:0] MODE_XFER   = 2'b11;

  localparam logic [3:0] HDMA1 = 4'h1;
  localparam logic [3:0] HDMA2 = 4'h2;
  localparam logic [3:0] HDMA3 = 4'h3;
  localparam logic [3:0] HDMA4 = 4'h4;
  localparam logic [3:0] HDMA5 = 4'h5;

endpackage

// File: rtl/hdma_byte_engine.sv
// Two-cycle-per-byte copy engine: read strobe, then VRAM write of the
// returned byte. Holds the source/destination pointers and counts bytes.
module hdma_byte_engine
  import video_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        src_hi_we,
  input  logic        src_lo_we,
  input  logic        dst_hi_we,
  input  logic        dst_lo_we,
  input  logic [7:0]  load_data,
  input  logic [7:0]  src_data,
  output logic        src_rd,
  output logic [15:0] src_addr,
  output logic        vram_wr,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_di,
  output logic        block_done,
  output logic        dst_wrap
);

  localparam logic [3:0] LAST_BYTE = 4'(BLOCK_BYTES - 1);

  logic        phase;
  logic [3:0]  byte_cnt;
  logic [15:0] src;
  logic [12:0] dst;

  // Pointers are only loadable while stopped; low nibbles are block-aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= 1'b0;
      byte_cnt <= 4'd0;
      src      <= 16'h0000;
      dst      <= 13'h0000;
    end else if (run) begin
      phase <= ~phase;
      if (phase) begin
        src      <= src + 16'd1;
        dst      <= dst + 13'd1;
        byte_cnt <= byte_cnt + 4'd1;
      end
    end else begin
      phase    <= 1'b0;
      byte_cnt <= 4'd0;
      if (src_hi_we) src[15:8] <= load_data;
      if (src_lo_we) src[7:0]  <= {load_data[7:4], 4'h0};
      if (dst_hi_we) dst[12:8] <= load_data[4:0];
      if (dst_lo_we) dst[7:0]  <= {load_data[7:4], 4'h0};
    end
  end

  assign src_rd     = run & ~phase;
  assign src_addr   = src;
  assign vram_wr    = run & phase;
  assign vram_addr  = dst;
  assign vram_di    = src_data;
  assign block_done = vram_wr && (byte_cnt == LAST_BYTE);
  assign dst_wrap   = block_done && (dst == 13'h1FFF);

endmodule

// File: rtl/hdma_controller.sv
// CGB VRAM DMA controller (FF51-FF55): general-purpose and HBlank-paced
// block copies from CPU space into VRAM, stalling the CPU while copying.
module hdma_controller
  import video_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cgb_mode,
  input  logic        cpu_sel_reg,
  input  logic [3:0]  cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  input  logic        lcd_on,
  input  logic [1:0]  ppu_mode,
  output logic        dma_busy,
  output logic        src_rd,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_data,
  output logic        vram_wr,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_di
);

  hdma_state_t state;
  logic [7:0]  blocks_left;
  logic        stop_req;
  logic        status_valid;
  logic [1:0]  prev_mode;

  logic        reg_wr, idle_wr, wr55, stop_wr;
  logic        xfer, hdma_active, hblank_edge, run;
  logic        block_done, dst_wrap;
  logic [7:0]  blocks_rem;

  assign reg_wr      = cgb_mode & cpu_sel_reg & cpu_wr;
  assign idle_wr     = reg_wr && (state == IDLE);
  assign wr55        = reg_wr && (cpu_addr == HDMA5);
  assign stop_wr     = wr55 && !cpu_di[7];
  assign xfer        = (state == GDMA_XFER) || (state == HDMA_XFER);
  assign hdma_active = (state == HDMA_WAIT) || (state == HDMA_XFER);
  assign hblank_edge = lcd_on && (prev_mode == MODE_XFER) && (ppu_mode == MODE_HBLANK);
  assign blocks_rem  = blocks_left - 8'd1;
  assign dma_busy    = xfer;
  // Gating with reset kills the strobes in the very cycle reset is raised.
  assign run         = xfer && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      blocks_left  <= 8'd0;
      stop_req     <= 1'b0;
      status_valid <= 1'b0;
      prev_mode    <= MODE_HBLANK;
    end else begin
      prev_mode <= ppu_mode;
      case (state)
        IDLE: begin
          if (wr55) begin
            blocks_left  <= {1'b0, cpu_di[6:0]} + 8'd1;
            status_valid <= 1'b1;
            stop_req     <= 1'b0;
            if (!cpu_di[7])   state <= GDMA_XFER;
            else if (lcd_on)  state <= HDMA_WAIT;
            else              state <= HDMA_XFER;
          end
        end
        GDMA_XFER: begin
          if (block_done) begin
            blocks_left <= blocks_rem;
            if (blocks_rem == 8'd0 || dst_wrap) begin
              state        <= IDLE;
              status_valid <= 1'b0;
            end
          end
        end
        HDMA_WAIT: begin
          if (stop_wr)          state <= IDLE;
          else if (hblank_edge) state <= HDMA_XFER;
        end
        HDMA_XFER: begin
          if (stop_wr) stop_req <= 1'b1;
          if (block_done) begin
            blocks_left <= blocks_rem;
            if (blocks_rem == 8'd0 || dst_wrap) begin
              state        <= IDLE;
              status_valid <= 1'b0;
            end else if (stop_req || stop_wr) begin
              state <= IDLE;
            end else begin
              state <= HDMA_WAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only FF55 reports status, and only after a start that has not completed.
  always_comb begin
    cpu_do = 8'hFF;
    if (cgb_mode && cpu_sel_reg && cpu_addr == HDMA5 && status_valid)
      cpu_do = {~hdma_active, blocks_rem[6:0]};
  end

  hdma_byte_engine u_engine (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .src_hi_we  (idle_wr && cpu_addr == HDMA1),
    .src_lo_we  (idle_wr && cpu_addr == HDMA2),
    .dst_hi_we  (idle_wr && cpu_addr == HDMA3),
    .dst_lo_we  (idle_wr && cpu_addr == HDMA4),
    .load_data  (cpu_di),
    .src_data   (src_data),
    .src_rd     (src_rd),
    .src_addr   (src_addr),
    .vram_wr    (vram_wr),
    .vram_addr  (vram_addr),
    .vram_di    (vram_di),
    .block_done (block_done),
    .dst_wrap   (dst_wrap)
  );

endmodule
